// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// 8N1 serial receiver. The asynchronous line is brought into the clk domain
// through a two-flop synchronizer, the start bit is confirmed at its
// midpoint, and every later bit (8 data bits, LSB first, and the stop bit) is
// sampled one full bit period after the previous sample, which places each
// sample near the centre of its bit.
//
// Parameters
//   CLKS_PER_BIT   clk cycles per serial bit; legal 4..1023, even values only
//
// Ports
//   clk            system clock, rising-edge active
//   rst            asynchronous, active-high reset
//   bit_in         asynchronous serial line, idles high
//   data_out[7:0]  last correctly framed byte, held until the next good frame
//   valid          one-cycle pulse: data_out has just been loaded
//   framing_error  one-cycle pulse: stop bit was sampled low
//   busy           high whenever the receiver is not idle
//
// States
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   IDLE       | line idle, waiting for a low level on the synchronized line
//   START      | counting to the start-bit midpoint to confirm it is real
//   DATA       | sampling the 8 data bits, one per bit period
//   STOP       | sampling the stop bit; emits valid or framing_error
//   BREAK_WAIT | stop bit was low; wait for the line to return high
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    // Wide enough to hold CLKS_PER_BIT-1 without wrapping.
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronizer. Both flops reset to the idle (high) level so that reset
    // release never looks like a start bit.
    // -----------------------------------------------------------------------
    logic sync_meta;
    logic rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync_meta <= bit_in;
            rx_s      <= sync_meta;
        end
    end

    // -----------------------------------------------------------------------
    // FSM and datapath registers
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q,  data_d;
    logic             valid_q, valid_d;
    logic             ferr_q,  ferr_d;
    logic             busy_q,  busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        // Low pulse shorter than half a bit: treat as noise.
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            BREAK_WAIT: begin
                // A line held low (break) must not be taken as a new start bit.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // busy is registered alongside the state, so it tracks state_q exactly.
    assign busy_d = (state_d != IDLE);

    assign data_out      = data_q;
    assign valid         = valid_q;
    assign framing_error = ferr_q;
    assign busy          = busy_q;

endmodule
